// File: rtl/cpu_pkg.sv
// Purpose: constants shared by the fetch unit, decoder and instruction ROM.
//   State encoding for the fetch FSM, instruction width, reset PC and the
//   bubble (NOP) word inserted into IF/ID on flushes.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned CNT_W   = 16;

  localparam logic [PC_W-1:0]    CPU_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] CPU_NOP_WORD = 32'h0000_0000;

  // Fetch FSM encoding (2-bit, kept as plain constants for legacy users)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

endpackage

// File: rtl/if_id_reg.sv
// Purpose: IF/ID pipeline register (instruction, PC, valid) with hold and
//   flush controls. Flush has priority over load; neither means hold.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   load_i           capture instr_i/pc_i as a valid instruction
//   flush_i          load a bubble (NOP_WORD, pc 0, valid 0)
//   instr_i, pc_i    fetched instruction and its PC
//   instr_o, pc_o    registered instruction and PC
//   valid_o          registered holds a real instruction
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W   = INSTR_W,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(CPU_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;

  // Next-value selection: flush > load > hold
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_WORD;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: fetch stage. Owns the PC, drives the ROM word address and
//   captures ROM data into IF/ID. Handles decode stalls, redirects (one
//   bubble) and halt.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_addr / imem_dout            ROM word address (from PC register) / data
//   stall_i, redirect_i, halt_i      pipeline controls
//   redirect_pc                      byte target, low two bits ignored
//   pc_o                             current fetch PC
//   if_id_instr/if_id_pc/if_id_valid IF/ID register contents
//   fetch_cnt                        saturating count of valid fetches
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 6,
  parameter int unsigned       DATA_W   = INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC = CPU_RESET_PC,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(CPU_NOP_WORD)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_dout,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_i,
  output logic [31:0]       pc_o,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              if_id_valid,
  output logic [15:0]       fetch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_load, if_flush;
  logic [PC_W-1:0]  redirect_tgt;
  logic             unused_redirect_lsbs;

  assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Next-state, next-PC, counter and IF/ID control
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    if_load  = 1'b0;
    if_flush = 1'b0;
    case (state_q)
      S_IDLE: begin
        // One bubble cycle after reset release, PC not advanced
        state_d  = S_RUN;
        if_flush = 1'b1;
      end
      S_RUN: begin
        if (redirect_i) begin
          pc_d     = redirect_tgt;
          if_flush = 1'b1;
        end else if (halt_i) begin
          // Halt outranks a coincident stall: the pipeline is draining anyway
          state_d  = S_HALT;
          if_flush = 1'b1;
        end else if (!stall_i) begin
          if_load = 1'b1;
          pc_d    = pc_q + 32'd4;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      S_HALT: begin
        if_flush = 1'b1;
        if (redirect_i) begin
          state_d = S_RUN;
          pc_d    = redirect_tgt;
        end
      end
      default: begin
        state_d  = S_IDLE;
        if_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Word address straight from the PC register; PCs beyond ROM depth wrap
  assign imem_addr = pc_q[ADDR_W+1:2];
  assign pc_o      = pc_q;
  assign fetch_cnt = cnt_q;

  if_id_reg #(
    .DATA_W   (DATA_W),
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (if_load),
    .flush_i (if_flush),
    .instr_i (imem_dout),
    .pc_i    (pc_q),
    .instr_o (if_id_instr),
    .pc_o    (if_id_pc),
    .valid_o (if_id_valid)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a behavioural fetch model.
module tb_instr_fetch_unit;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DEPTH  = 64;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_dout;
  logic              stall_i;
  logic              redirect_i;
  logic [31:0]       redirect_pc;
  logic              halt_i;
  logic [31:0]       pc_o;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc;
  logic              if_id_valid;
  logic [15:0]       fetch_cnt;

  logic [31:0] rom [DEPTH];

  int checks;
  int errors;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (32),
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_dout   (imem_dout),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .redirect_pc (redirect_pc),
    .halt_i      (halt_i),
    .pc_o        (pc_o),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid),
    .fetch_cnt   (fetch_cnt)
  );

  assign imem_dout = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected ROM content at a byte PC (word k holds 0x1000_0000 + k)
  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'h1000_0000 + ((pc / 4) % DEPTH);
  endfunction

  task automatic set_in(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic hl);
    stall_i     = st;
    redirect_i  = rd;
    redirect_pc = rpc;
    halt_i      = hl;
  endtask

  // Advance one clock; outputs settle 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++;
    if (pc_o !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        if_id_pc !== 32'h0 || fetch_cnt !== 16'h0 || imem_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: pc=%h valid=%b instr=%h ifpc=%h cnt=%0d addr=%0d, want all zero",
               pc_o, if_id_valid, if_id_instr, if_id_pc, fetch_cnt, imem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reset release: one bubble, then sequential words (ends with pc_o = 0x8)
  task automatic test_free_run();
    tick();
    checks++;
    if (if_id_valid !== 1'b0 || pc_o !== 32'h0 || fetch_cnt !== 16'd0) begin
      errors++;
      $display("FAIL first_bubble: valid=%b pc=%h cnt=%0d, want 0/00000000/0",
               if_id_valid, pc_o, fetch_cnt);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (if_id_valid !== 1'b1 || if_id_instr !== 32'h1000_0000 + 32'(k) ||
          if_id_pc !== 32'(4 * k) || fetch_cnt !== 16'(k + 1) || pc_o !== 32'(4 * (k + 1))) begin
        errors++;
        $display("FAIL free_run[%0d]: valid=%b instr=%h ifpc=%h cnt=%0d pc=%h, want 1/%h/%h/%0d/%h",
                 k, if_id_valid, if_id_instr, if_id_pc, fetch_cnt, pc_o,
                 32'h1000_0000 + 32'(k), 32'(4 * k), k + 1, 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_stall();
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (pc_o !== 32'h8 || if_id_instr !== 32'h1000_0001 || if_id_pc !== 32'h4 ||
          if_id_valid !== 1'b1 || fetch_cnt !== 16'd2) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h ifpc=%h valid=%b cnt=%0d, want 8/10000001/4/1/2",
                 k, pc_o, if_id_instr, if_id_pc, if_id_valid, fetch_cnt);
      end
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++;
    if (if_id_instr !== 32'h1000_0002 || if_id_pc !== 32'h8 || fetch_cnt !== 16'd3 ||
        pc_o !== 32'hC) begin
      errors++;
      $display("FAIL stall_release: instr=%h ifpc=%h cnt=%0d pc=%h, want 10000002/8/3/c",
               if_id_instr, if_id_pc, fetch_cnt, pc_o);
    end
  endtask

  task automatic test_redirect_over_stall();
    set_in(1'b1, 1'b1, 32'h23, 1'b0);
    tick();
    checks++;
    if (pc_o !== 32'h20 || if_id_valid !== 1'b0 || fetch_cnt !== 16'd3) begin
      errors++;
      $display("FAIL redirect_bubble: pc=%h valid=%b cnt=%0d, want 20/0/3", pc_o, if_id_valid, fetch_cnt);
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++;
    if (if_id_instr !== 32'h1000_0008 || if_id_pc !== 32'h20 || if_id_valid !== 1'b1 ||
        fetch_cnt !== 16'd4) begin
      errors++;
      $display("FAIL redirect_target: instr=%h ifpc=%h valid=%b cnt=%0d, want 10000008/20/1/4",
               if_id_instr, if_id_pc, if_id_valid, fetch_cnt);
    end
  endtask

  task automatic test_pc_wrap();
    set_in(1'b0, 1'b1, 32'hFC, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++;
    if (if_id_instr !== 32'h1000_003F || if_id_pc !== 32'hFC || pc_o !== 32'h100 ||
        imem_addr !== 6'd0) begin
      errors++;
      $display("FAIL wrap_last: instr=%h ifpc=%h pc=%h addr=%0d, want 1000003f/fc/100/0",
               if_id_instr, if_id_pc, pc_o, imem_addr);
    end
    tick();
    checks++;
    if (if_id_instr !== 32'h1000_0000 || if_id_pc !== 32'h100 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_first: instr=%h ifpc=%h valid=%b, want 10000000/100/1",
               if_id_instr, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_halt();
    logic [15:0] cnt_at_halt;
    set_in(1'b0, 1'b1, 32'h10, 1'b0);
    tick();
    cnt_at_halt = fetch_cnt;
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (if_id_valid !== 1'b0 || pc_o !== 32'h10 || fetch_cnt !== cnt_at_halt) begin
        errors++;
        $display("FAIL halt_frozen[%0d]: valid=%b pc=%h cnt=%0d, want 0/10/%0d",
                 k, if_id_valid, pc_o, fetch_cnt, cnt_at_halt);
      end
      tick();
    end
    set_in(1'b0, 1'b1, 32'h4, 1'b0);
    tick();
    checks++;
    if (pc_o !== 32'h4 || if_id_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_redirect: pc=%h valid=%b, want 4/0", pc_o, if_id_valid);
    end
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    checks++;
    if (if_id_instr !== 32'h1000_0001 || if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL halt_resume: instr=%h ifpc=%h valid=%b, want 10000001/4/1",
               if_id_instr, if_id_pc, if_id_valid);
    end
  endtask

  task automatic test_async_reset();
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 ||
        fetch_cnt !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: pc=%h valid=%b instr=%h cnt=%0d, want all zero",
               pc_o, if_id_valid, if_id_instr, fetch_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Randomized controls against a behavioural fetch model
  task automatic test_random();
    logic [31:0] m_pc, m_instr, m_ifpc, rpc;
    bit          m_valid, m_halted, m_started, st, rd, hl;
    int          m_cnt;
    apply_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0; m_started = 1'b0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(99) < 25);
      rd  = ($urandom_range(99) < 10);
      rpc = ($urandom_range(9) == 0) ? $urandom() : 32'($urandom_range(511));
      // Halt is only raised when it cannot coincide with a lone stall
      hl  = ($urandom_range(99) < 5) && !st;
      set_in(st, rd, rpc, hl);
      tick();
      if (!m_started) begin
        m_started = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
      end else if (rd) begin
        m_pc = rpc & ~32'h3; m_halted = 1'b0; m_valid = 1'b0; m_instr = 32'h0;
      end else if (m_halted || hl) begin
        m_halted = 1'b1; m_valid = 1'b0; m_instr = 32'h0;
      end else if (!st) begin
        m_instr = rom_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
        if (m_cnt < 65535) m_cnt++;
      end
      checks++;
      if (pc_o !== m_pc || if_id_valid !== m_valid || fetch_cnt !== 16'(m_cnt) ||
          imem_addr !== 6'((m_pc / 4) % DEPTH) || if_id_instr !== m_instr ||
          (m_valid && if_id_pc !== m_ifpc)) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h valid=%b cnt=%0d instr=%h ifpc=%h addr=%0d, want %h/%b/%0d/%h/%h",
                 i, pc_o, if_id_valid, fetch_cnt, if_id_instr, if_id_pc, imem_addr,
                 m_pc, m_valid, m_cnt, m_instr, m_ifpc);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < DEPTH; k++) rom[k] = 32'h1000_0000 + 32'(k);
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_over_stall();
    test_pc_wrap();
    test_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
